gpio_edge_irq: RTL and testbench

GPIO_EDGE_IRQ -- requirements
Module: gpio_edge_irq

---
 rtl/gpio_edge_irq_if.sv | 21 ++
 rtl/gpio_edge_irq.sv | 110 +++++++++++
 tb/tb_gpio_edge_irq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gpio_edge_irq_if.sv
// rtl/gpio_edge_irq_if.sv - CPU register bus for gpio_edge_irq
interface gpio_edge_irq_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;

    modport master (
        output address,
        output write_data,
        output write_enable,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  write_enable,
        output read_data
    );
endinterface

// File: rtl/gpio_edge_irq.sv
// rtl/gpio_edge_irq.sv - 8-pin GPIO with sync, debounce and edge-pending interrupt
module gpio_edge_irq #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0020
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gpio_edge_irq_if.slave        bus,
    input  logic [7:0]            gpio_in,
    output logic                  irq
);
    localparam logic [31:0] ADDR_IN     = BASE_ADDR;
    localparam logic [31:0] ADDR_EDGE   = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h8;
    localparam logic [31:0] ADDR_DB     = BASE_ADDR + 32'hC;

    logic [7:0]        s1_q, s1_d, s2_q, s2_d;
    logic [7:0]        stable_q, stable_d;
    logic [7:0][15:0]  cnt_q, cnt_d;
    logic [7:0]        rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [7:0]        pend_q, pend_d;
    logic [15:0]       db_q, db_d;
    logic              irq_q, irq_d;

    logic [15:0]       d_eff;
    logic [7:0]        set_bits, clr_bits;
    logic              unused_wdata;

    assign unused_wdata = ^bus.write_data[31:16];

    always_comb begin
        s1_d      = gpio_in;
        s2_d      = s1_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        db_d      = db_q;
        clr_bits  = 8'h00;

        // A debounce value of 0 behaves like 1: commit on the first mismatch cycle.
        d_eff = (db_q == 16'd0) ? 16'd1 : db_q;

        for (int i = 0; i < 8; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = 16'd0;
            end else if (({1'b0, cnt_q[i]} + 17'd1) >= {1'b0, d_eff}) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = 16'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end

        set_bits = (stable_d & ~stable_q & rise_en_q) |
                   (~stable_d & stable_q & fall_en_q);

        if (bus.write_enable) begin
            case (bus.address)
                ADDR_EDGE: begin
                    rise_en_d = bus.write_data[7:0];
                    fall_en_d = bus.write_data[15:8];
                end
                ADDR_STATUS: clr_bits = bus.write_data[7:0];
                ADDR_DB:     db_d     = bus.write_data[15:0];
                default: ;
            endcase
        end

        // Set wins over a same-edge W1C clear.
        pend_d = (pend_q & ~clr_bits) | set_bits;
        irq_d  = |pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            db_q      <= '0;
            irq_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            db_q      <= db_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        bus.read_data = 32'h0;
        case (bus.address)
            ADDR_IN:     bus.read_data = {24'h0, stable_q};
            ADDR_EDGE:   bus.read_data = {16'h0, fall_en_q, rise_en_q};
            ADDR_STATUS: bus.read_data = {24'h0, pend_q};
            ADDR_DB:     bus.read_data = {16'h0, db_q};
            default:     bus.read_data = 32'h0;
        endcase
    end

    assign irq = irq_q;
endmodule

// File: tb/tb_gpio_edge_irq.sv
// tb/tb_gpio_edge_irq.sv - scoreboard bench for gpio_edge_irq
module tb_gpio_edge_irq;
    localparam logic [31:0] BASE = 32'hFFFF0020;
    localparam logic [31:0] A_IN = BASE;
    localparam logic [31:0] A_EDGE = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_DB = BASE + 32'hC;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] gpio_in;
    logic       irq;
    logic       rd_req;
    int         tests;
    int         fails;
    exp_t       sb[$];

    gpio_edge_irq_if bus ();

    gpio_edge_irq #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .gpio_in (gpio_in),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.address      = a;
        bus.write_data   = d;
        bus.write_enable = 1'b1;
        step(1);
        bus.write_enable = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a,
                      input logic [31:0] d, input logic ei);
        exp_t e;
        e.name = nm;
        e.data = d;
        e.irq  = ei;
        bus.address = a;
        sb.push_back(e);
        rd_req = 1'b1;
        #2;
        rd_req = 1'b0;
        #1;
    endtask

    // Monitor: samples mid-pulse, away from clock edges.
    initial begin
        forever begin
            @(posedge rd_req);
            #1;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_underflow read_data=%h", bus.read_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.read_data !== e.data || irq !== e.irq) begin
                    fails++;
                    $display("FAIL %s: got data=%h irq=%b, expected data=%h irq=%b",
                             e.name, bus.read_data, irq, e.data, e.irq);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rd_req = 1'b0;
        rst_n = 1'b0;
        gpio_in = 8'h00;
        bus.address = 32'h0;
        bus.write_data = 32'h0;
        bus.write_enable = 1'b0;
        step(2);
        rd("rst_in", A_IN, 32'h0, 1'b0);
        rd("rst_edge", A_EDGE, 32'h0, 1'b0);
        rd("rst_status", A_STAT, 32'h0, 1'b0);
        rd("rst_db", A_DB, 32'h0, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Rising edge, no debounce: 3 edges to stable.
        wr(A_DB, 32'h0);
        wr(A_EDGE, 32'h01);
        gpio_in = 8'h01;
        step(1);
        rd("rise_e1", A_IN, 32'h0, 1'b0);
        step(1);
        rd("rise_e2", A_IN, 32'h0, 1'b0);
        step(1);
        rd("rise_e3_in", A_IN, 32'h01, 1'b1);
        rd("rise_e3_stat", A_STAT, 32'h01, 1'b1);
        wr(A_STAT, 32'h01);
        rd("rise_clr", A_STAT, 32'h0, 1'b0);

        // Debounce 4, falling edge on pin 3.
        wr(A_EDGE, 32'h0800);
        wr(A_DB, 32'h4);
        gpio_in = 8'h09;
        step(10);
        rd("pin3_high", A_IN, 32'h09, 1'b0);
        rd("pin3_high_stat", A_STAT, 32'h0, 1'b0);
        gpio_in = 8'h01;
        step(3);
        gpio_in = 8'h09;
        step(10);
        rd("glitch_in", A_IN, 32'h09, 1'b0);
        rd("glitch_stat", A_STAT, 32'h0, 1'b0);
        gpio_in = 8'h01;
        step(5);
        rd("fall_k4", A_IN, 32'h09, 1'b0);
        step(1);
        rd("fall_k5_in", A_IN, 32'h01, 1'b1);
        rd("fall_k5_stat", A_STAT, 32'h08, 1'b1);
        wr(A_STAT, 32'h08);

        // Partial W1C.
        wr(A_DB, 32'h0);
        wr(A_EDGE, 32'h05);
        gpio_in = 8'h00;
        step(4);
        gpio_in = 8'h05;
        step(3);
        rd("pend05", A_STAT, 32'h05, 1'b1);
        wr(A_STAT, 32'h04);
        rd("w1c_04", A_STAT, 32'h01, 1'b1);
        wr(A_STAT, 32'h01);
        rd("w1c_01", A_STAT, 32'h0, 1'b0);

        // Same-edge set and clear of pend[2].
        gpio_in = 8'h01;
        step(3);
        gpio_in = 8'h05;
        step(3);
        rd("pend2_pre", A_STAT, 32'h04, 1'b1);
        gpio_in = 8'h01;
        step(3);
        gpio_in = 8'h05;
        step(2);
        wr(A_STAT, 32'h04);
        rd("set_wins", A_STAT, 32'h04, 1'b1);
        wr(A_STAT, 32'h04);
        rd("set_wins_clr", A_STAT, 32'h0, 1'b0);

        // Unmapped and read-only accesses.
        rd("unmapped_rd", BASE + 32'h10, 32'h0, 1'b0);
        wr(A_EDGE, 32'hFFFF_FFFF);
        rd("edge_upper", A_EDGE, 32'h0000_FFFF, 1'b0);
        wr(A_EDGE, 32'h0);
        wr(A_DB, 32'hFFFF_1234);
        rd("db_upper", A_DB, 32'h0000_1234, 1'b0);
        wr(A_IN, 32'hAA);
        rd("in_ro", A_IN, 32'h05, 1'b0);
        wr(BASE + 32'h10, 32'hFF);
        rd("unmapped_wr", A_STAT, 32'h0, 1'b0);

        // New debounce value commits an already-long count on the next edge.
        wr(A_DB, 32'd100);
        gpio_in = 8'h04;
        step(7);
        wr(A_DB, 32'd3);
        rd("db_change_wr_edge", A_IN, 32'h05, 1'b0);
        step(1);
        rd("db_change_commit", A_IN, 32'h04, 1'b0);

        // Reset mid-debounce, pins held high.
        wr(A_DB, 32'd100);
        wr(A_EDGE, 32'h0101);
        gpio_in = 8'hFF;
        step(10);
        rst_n = 1'b0;
        #1;
        rd("rst_mid_in", A_IN, 32'h0, 1'b0);
        rd("rst_mid_edge", A_EDGE, 32'h0, 1'b0);
        rd("rst_mid_db", A_DB, 32'h0, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(2);
        rd("rel_e2", A_IN, 32'h0, 1'b0);
        step(1);
        rd("rel_e3_in", A_IN, 32'hFF, 1'b0);
        rd("rel_e3_stat", A_STAT, 32'h0, 1'b0);

        #20;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
